// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants, decoder state encoding and key-code type for the PS/2 front end.
// Pure declarations: no latency, no flow control.
package ps2_key_decoder_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR_LO = 8'h00;
  localparam logic [7:0] SC_ERR_HI = 8'hFF;

  localparam logic [8:0] KEY_CODE_ENTER = 9'd90;
  localparam int         PAUSE_TAIL_LEN = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXT   = 2'd1,
    BREAK = 2'd2,
    SKIP  = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_code_t;

  // Controller responses and error codes that never describe a key.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
           (b == SC_ECHO) || (b == SC_ERR_LO) || (b == SC_ERR_HI);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// Synchronises PS/2 lines and assembles 11-bit frames; byte_valid/frame_err pulse 1 cycle after the stop edge.
// No backpressure: the keyboard cannot be stalled, every byte is presented exactly once.
module ps2_frame_rx
  #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int SYNC_STAGES    = 2
  )
  (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
  );

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_cur;
  logic                   data_cur;
  logic                   fall;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   par_bit;
  logic [TW-1:0]          timer;

  assign clk_cur  = clk_sync[SYNC_STAGES-1];
  assign data_cur = data_sync[SYNC_STAGES-1];
  assign fall     = clk_prev & ~clk_cur;

  // Idle bus level is high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= 4'd0;
      shift      <= 8'd0;
      par_bit    <= 1'b0;
      timer      <= '0;
      rx_byte    <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        timer <= '0;
        if (bit_cnt == 4'd0) begin
          if (!data_cur) bit_cnt <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shift   <= {data_cur, shift[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          par_bit <= data_cur;
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= 4'd0;
          if (data_cur && (^{shift, par_bit})) begin
            byte_valid <= 1'b1;
            rx_byte    <= shift;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (bit_cnt != 4'd0) begin
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          timer     <= '0;
          bit_cnt   <= 4'd0;
          frame_err <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 scan-code decoder: maintains pressed-key bitmap, last change and event strobe from PS/2 frames.
// Outputs register 1 cycle after the internal byte strobe; no backpressure, events are never stalled.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
  #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int SYNC_STAGES    = 2
  )
  (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         been_ready,
    output logic         frame_err
  );

  logic       byte_valid;
  logic [7:0] rx_byte;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_frame_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  dec_state_t state_q, state_d;
  logic       ext_q, ext_d;
  logic [2:0] skip_q, skip_d;
  logic       ev_vld;
  logic       ev_make;
  key_code_t  ev_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ext_q   <= 1'b0;
      skip_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    skip_d  = skip_q;
    if (frame_err) begin
      // A damaged byte may have been part of a prefix sequence, so drop it all.
      state_d = IDLE;
      ext_d   = 1'b0;
      skip_d  = 3'd0;
    end else if (byte_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_byte == SC_EXT) begin
            state_d = EXT;
            ext_d   = 1'b1;
          end else if (rx_byte == SC_BREAK) begin
            state_d = BREAK;
          end else if (rx_byte == SC_PAUSE) begin
            state_d = SKIP;
            skip_d  = 3'(PAUSE_TAIL_LEN);
          end else begin
            ext_d = 1'b0;
          end
        end
        EXT: begin
          if (rx_byte == SC_BREAK) begin
            state_d = BREAK;
          end else if (rx_byte != SC_EXT) begin
            state_d = IDLE;
            ext_d   = 1'b0;
          end
        end
        BREAK: begin
          state_d = IDLE;
          ext_d   = 1'b0;
        end
        SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          ext_d   = 1'b0;
          skip_d  = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    ev_vld       = 1'b0;
    ev_make      = 1'b1;
    ev_code.ext  = ext_q;
    ev_code.code = rx_byte;
    if (byte_valid && !frame_err) begin
      case (state_q)
        IDLE:    ev_vld = (rx_byte != SC_EXT) && (rx_byte != SC_BREAK) &&
                          (rx_byte != SC_PAUSE) && !is_ignored(rx_byte);
        EXT:     ev_vld = (rx_byte != SC_BREAK) && (rx_byte != SC_EXT);
        BREAK: begin
          ev_vld  = 1'b1;
          ev_make = 1'b0;
        end
        default: ev_vld = 1'b0;
      endcase
    end
  end

  // Typematic repeats rewrite the same bit, so key_down is unchanged but the strobe still fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_down    <= '0;
      last_change <= 9'd0;
      been_ready  <= 1'b0;
    end else begin
      been_ready <= ev_vld;
      if (ev_vld) begin
        key_down[ev_code] <= ev_make;
        last_change       <= ev_code;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor pops and compares on each strobe.
module tb_ps2_key_decoder;
  import ps2_key_decoder_pkg::*;

  localparam int TO   = 200;
  localparam int HALF = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ps2_clk = 1'b1;
  logic         ps2_data = 1'b1;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         been_ready;
  logic         frame_err;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_down    (key_down),
    .last_change (last_change),
    .been_ready  (been_ready),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         is_err;
    logic [8:0]   code;
    logic [511:0] kd;
  } exp_t;

  exp_t         q[$];
  logic [511:0] model = '0;
  int           rst_req = 0;
  int           rst_seen = 0;
  logic         done = 1'b0;
  int           errors = 0;
  int           checks = 0;
  logic         prev_br = 1'b0;

  task automatic push_make(input logic [8:0] c);
    exp_t e;
    model[c] = 1'b1;
    e.is_err = 1'b0; e.code = c; e.kd = model;
    q.push_back(e);
  endtask

  task automatic push_break(input logic [8:0] c);
    exp_t e;
    model[c] = 1'b0;
    e.is_err = 1'b0; e.code = c; e.kd = model;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.code = 9'd0; e.kd = model;
    q.push_back(e);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    logic p;
    p = ~(^d) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
  endtask

  // Monitor: sole owner of the counters.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen != rst_req) begin
      rst_seen = rst_req;
      checks += 4;
      if (key_down !== '0)     begin errors++; $display("FAIL reset_key_down got=%h want=0", key_down); end
      if (last_change !== 9'd0) begin errors++; $display("FAIL reset_last_change got=%h want=0", last_change); end
      if (been_ready !== 1'b0) begin errors++; $display("FAIL reset_been_ready got=%b want=0", been_ready); end
      if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    end
    if (!rst) begin
      if (prev_br) begin
        checks++;
        if (been_ready) begin errors++; $display("FAIL strobe_width been_ready high 2 cycles want 1"); end
      end
      checks++;
      if (been_ready && frame_err) begin errors++; $display("FAIL coincide been_ready=1 frame_err=1 want at most one"); end
      if (been_ready || frame_err) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event been_ready=%b frame_err=%b last_change=%h want none", been_ready, frame_err, last_change);
        end else begin
          e = q.pop_front();
          if (e.is_err !== frame_err || (!e.is_err && last_change !== e.code)) begin
            errors++;
            $display("FAIL event_kind got err=%b code=%h want err=%b code=%h", frame_err, last_change, e.is_err, e.code);
          end
          checks++;
          if (key_down !== e.kd) begin
            errors++;
            $display("FAIL key_down bitmap got_set90=%b set175=%b set75=%b want_set90=%b set175=%b set75=%b",
                     key_down[90], key_down[9'h175], key_down[9'h075], e.kd[90], e.kd[9'h175], e.kd[9'h075]);
          end
        end
      end
      prev_br = been_ready;
    end else begin
      prev_br = 1'b0;
    end
    if (done) begin
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL missing_events got_pending=%0d want=0", q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (5) @(posedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    rst_req++;
    repeat (3) @(posedge clk);

    // Make, break, typematic repeat of Enter.
    push_make(KEY_CODE_ENTER);
    send_frame(8'h5A, 1'b0);
    push_break(KEY_CODE_ENTER);
    send_frame(SC_BREAK, 1'b0);
    send_frame(8'h5A, 1'b0);
    push_make(KEY_CODE_ENTER);
    push_make(KEY_CODE_ENTER);
    send_frame(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b0);

    // Extended key alongside its non-extended twin, plus ignored responses.
    push_make(9'h075);
    send_frame(8'h75, 1'b0);
    send_frame(SC_ACK, 1'b0);
    send_frame(SC_BAT, 1'b0);
    push_make(9'h175);
    send_frame(SC_EXT, 1'b0);
    send_frame(8'h75, 1'b0);
    push_break(9'h175);
    send_frame(SC_EXT, 1'b0);
    send_frame(SC_BREAK, 1'b0);
    send_frame(8'h75, 1'b0);

    // Parity errors, including one that must drop a pending E0.
    push_err();
    send_frame(8'h1C, 1'b1);
    push_err();
    push_make(9'h01C);
    send_frame(SC_EXT, 1'b0);
    send_frame(8'h1C, 1'b1);
    send_frame(8'h1C, 1'b0);

    // Timeout after 5 edges, then a clean frame.
    push_err();
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    ps2_data = 1'b1;
    repeat (TO + 100) @(posedge clk);
    push_make(9'h029);
    send_frame(8'h29, 1'b0);
    wait_drain();

    // Reset in the middle of a frame.
    for (int i = 0; i < 5; i++) ps2_bit(1'b1 ^ i[0]);
    ps2_data = 1'b1;
    rst = 1'b1;
    model = '0;
    repeat (3) @(posedge clk);
    rst_req++;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    push_make(KEY_CODE_ENTER);
    send_frame(8'h5A, 1'b0);

    // Pause sequence is swallowed completely.
    send_frame(SC_PAUSE, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(8'h77, 1'b0);
    send_frame(SC_PAUSE, 1'b0);
    send_frame(SC_BREAK, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(SC_BREAK, 1'b0);
    send_frame(8'h77, 1'b0);
    push_make(KEY_CODE_ENTER);
    send_frame(8'h5A, 1'b0);

    wait_drain();
    repeat (10) @(posedge clk);
    done = 1'b1;
  end

endmodule
